// File: rtl/ysyx_24100006_axi_sram.sv
// rtl/ysyx_24100006_axi_sram.sv - AXI4 SRAM slave with INCR read bursts, strobed writes and randomised latency
//
// Word-organised register-array memory behind independent read and write channels.
// A free-running 8-bit LFSR supplies a per-request delay so upstream handshakes see
// varying response times.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   axi_ar*  (valid/ready/addr/len/size)       read address channel
//   axi_r*   (valid/ready/data/resp/last)      read data channel
//   axi_aw*  (valid/ready/addr/len/size)       write address channel (single beat)
//   axi_w*   (valid/ready/data/strb/last)      write data channel, data lane-aligned
//   axi_b*   (valid/ready/resp)                write response channel
module ysyx_24100006_axi_sram #(
  parameter int          MEM_AW    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          LAT_MIN   = 1,
  parameter logic [3:0]  LAT_MASK  = 4'h7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  input  logic [31:0] axi_araddr,
  input  logic [7:0]  axi_arlen,
  input  logic [2:0]  axi_arsize,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        axi_rlast,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [31:0] axi_awaddr,
  input  logic [7:0]  axi_awlen,
  input  logic [2:0]  axi_awsize,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  input  logic        axi_wlast,
  output logic        axi_bvalid,
  input  logic        axi_bready,
  output logic [1:0]  axi_bresp
);
  localparam int         DEPTH = 1 << MEM_AW;
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  localparam logic [1:0] R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2;
  localparam logic [1:0] W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2;

  // Every access is a full word and writes are single-beat, so these carry no information.
  logic unused;
  assign unused = ^{axi_arsize, axi_awlen, axi_awsize, axi_wlast};

  logic [31:0] mem [DEPTH];

  // Latency source: x^8+x^6+x^5+x^4+1, advancing every cycle.
  logic [7:0] lfsr;
  logic [7:0] dly;
  always_ff @(posedge clk) begin
    if (reset) lfsr <= 8'hA5;
    else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
  assign dly = 8'(LAT_MIN) + {4'b0, lfsr[3:0] & LAT_MASK};

  // ---------------- read channel ----------------
  logic [1:0]        r_state;
  logic [7:0]        r_cnt, r_len, r_beat;
  logic [MEM_AW-1:0] r_idx;
  logic              r_oor;
  logic [31:0]       r_data;
  logic [31:0]       ar_off;
  logic              ar_oor, ar_hs, r_hs;

  assign ar_off      = axi_araddr - BASE_ADDR;
  assign ar_oor      = {1'b0, ar_off} >= SPAN;
  assign axi_arready = !reset && (r_state == R_IDLE);
  assign axi_rvalid  = !reset && (r_state == R_DATA);
  assign axi_rdata   = r_data;
  assign axi_rresp   = r_oor ? 2'b11 : 2'b00;
  assign axi_rlast   = (r_beat == r_len);
  assign ar_hs       = axi_arvalid && axi_arready;
  assign r_hs        = axi_rvalid && axi_rready;

  // Read data is registered so a write commit cannot disturb a stalled beat.
  logic              r_load, r_load_oor;
  logic [MEM_AW-1:0] r_load_idx;
  always_comb begin
    r_load     = 1'b0;
    r_load_idx = r_idx;
    r_load_oor = r_oor;
    case (r_state)
      R_IDLE: if (ar_hs && dly == 8'd0) begin
        r_load     = 1'b1;
        r_load_idx = ar_off[MEM_AW+1:2];
        r_load_oor = ar_oor;
      end
      R_WAIT: r_load = (r_cnt == 8'd1);
      R_DATA: if (r_hs && !axi_rlast) begin
        r_load     = 1'b1;
        r_load_idx = r_idx + MEM_AW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= R_IDLE;
      r_cnt   <= 8'd0;
      r_len   <= 8'd0;
      r_beat  <= 8'd0;
      r_idx   <= '0;
      r_oor   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (ar_hs) begin
          r_len   <= axi_arlen;
          r_beat  <= 8'd0;
          r_idx   <= ar_off[MEM_AW+1:2];
          r_oor   <= ar_oor;
          r_cnt   <= dly;
          r_state <= (dly == 8'd0) ? R_DATA : R_WAIT;
        end
        R_WAIT: begin
          if (r_cnt == 8'd1) r_state <= R_DATA;
          r_cnt <= r_cnt - 8'd1;
        end
        R_DATA: if (r_hs) begin
          if (axi_rlast) begin
            r_state <= R_IDLE;
          end else begin
            r_beat <= r_beat + 8'd1;
            r_idx  <= r_load_idx;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_load) r_data <= r_load_oor ? 32'h0 : mem[r_load_idx];
  end

  // ---------------- write channel ----------------
  logic [1:0]  w_state;
  logic [7:0]  w_cnt;
  logic        aw_got, w_got;
  logic [31:0] aw_addr_q, w_data_q;
  logic [3:0]  w_strb_q;
  logic        aw_hs, w_hs, wr_go, commit, wr_oor;
  logic [31:0] wr_addr, wr_data, wr_off;
  logic [3:0]  wr_strb;

  assign axi_awready = !reset && (w_state == W_IDLE) && !aw_got;
  assign axi_wready  = !reset && (w_state == W_IDLE) && !w_got;
  assign axi_bvalid  = !reset && (w_state == W_RESP);
  assign aw_hs       = axi_awvalid && axi_awready;
  assign w_hs        = axi_wvalid && axi_wready;

  // Live bus values in the capturing cycle, latched copies once captured.
  assign wr_addr   = aw_got ? aw_addr_q : axi_awaddr;
  assign wr_data   = w_got ? w_data_q : axi_wdata;
  assign wr_strb   = w_got ? w_strb_q : axi_wstrb;
  assign wr_off    = wr_addr - BASE_ADDR;
  assign wr_oor    = {1'b0, wr_off} >= SPAN;
  assign axi_bresp = wr_oor ? 2'b11 : 2'b00;
  assign wr_go     = (w_state == W_IDLE) && (aw_got || aw_hs) && (w_got || w_hs);
  assign commit    = !reset && !wr_oor &&
                     ((wr_go && dly == 8'd0) || (w_state == W_WAIT && w_cnt == 8'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state <= W_IDLE;
      w_cnt   <= 8'd0;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_got    <= 1'b1;
            aw_addr_q <= axi_awaddr;
          end
          if (w_hs) begin
            w_got    <= 1'b1;
            w_data_q <= axi_wdata;
            w_strb_q <= axi_wstrb;
          end
          if (wr_go) begin
            w_cnt   <= dly;
            w_state <= (dly == 8'd0) ? W_RESP : W_WAIT;
          end
        end
        W_WAIT: begin
          if (w_cnt == 8'd1) w_state <= W_RESP;
          w_cnt <= w_cnt - 8'd1;
        end
        W_RESP: if (axi_bvalid && axi_bready) begin
          w_state <= W_IDLE;
          aw_got  <= 1'b0;
          w_got   <= 1'b0;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_strb[i]) mem[wr_off[MEM_AW+1:2]][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_ysyx_24100006_axi_sram.sv
// tb/tb_ysyx_24100006_axi_sram.sv - scoreboard bench for ysyx_24100006_axi_sram (fixed and random latency instances)
module tb_ysyx_24100006_axi_sram;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        arvalid [2], arready [2], rvalid [2], rready [2], rlast [2];
  logic [31:0] araddr [2], rdata [2];
  logic [7:0]  arlen [2];
  logic [2:0]  arsize [2], awsize [2];
  logic [1:0]  rresp [2], bresp [2];
  logic        awvalid [2], awready [2], wvalid [2], wready [2], wlast [2], bvalid [2], bready [2];
  logic [31:0] awaddr [2], wdata [2];
  logic [7:0]  awlen [2];
  logic [3:0]  wstrb [2];

  // Instance 0: fixed latency of 1.  Instance 1: latency 1..8 from the LFSR.
  for (genvar g = 0; g < 2; g++) begin : duts
    ysyx_24100006_axi_sram #(
      .MEM_AW(12), .BASE_ADDR(32'h8000_0000), .LAT_MIN(1), .LAT_MASK(g == 0 ? 4'h0 : 4'h7)
    ) u_dut (
      .clk(clk), .reset(reset),
      .axi_arvalid(arvalid[g]), .axi_arready(arready[g]), .axi_araddr(araddr[g]),
      .axi_arlen(arlen[g]), .axi_arsize(arsize[g]),
      .axi_rvalid(rvalid[g]), .axi_rready(rready[g]), .axi_rdata(rdata[g]),
      .axi_rresp(rresp[g]), .axi_rlast(rlast[g]),
      .axi_awvalid(awvalid[g]), .axi_awready(awready[g]), .axi_awaddr(awaddr[g]),
      .axi_awlen(awlen[g]), .axi_awsize(awsize[g]),
      .axi_wvalid(wvalid[g]), .axi_wready(wready[g]), .axi_wdata(wdata[g]),
      .axi_wstrb(wstrb[g]), .axi_wlast(wlast[g]),
      .axi_bvalid(bvalid[g]), .axi_bready(bready[g]), .axi_bresp(bresp[g])
    );
  end

  typedef struct {logic [31:0] data; logic [1:0] resp; logic last;} rbeat_t;
  rbeat_t     rq[$];
  logic [1:0] bq[$];
  logic [31:0] model [2][4096];

  int checks = 0, failures = 0;
  int cyc = 0, ar_cyc = 0, w_cyc = 0, r_done = 0, b_done = 0, rmode = 0;
  bit r_first = 0, b_first = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_rng(input string name, input int v, input int lo, input int hi);
    checks++;
    if (v < lo || v > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, v, lo, hi, cyc);
    end
  endtask

  // Ready drivers and monitors, one per instance.
  for (genvar g = 0; g < 2; g++) begin : mon
    localparam int HI = (g == 0) ? 1 : 8;
    logic [34:0] r_hold;
    logic [1:0]  b_hold;
    bit          r_stall = 0, b_stall = 0;
    rbeat_t      e;

    initial forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       rready[g] = 1'b1;
        1:       rready[g] = !rready[g];
        default: rready[g] = ($urandom_range(0, 3) != 0);
      endcase
      bready[g] = (rmode == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    initial forever begin
      @(negedge clk);
      if (reset) begin
        r_stall = 0;
        b_stall = 0;
      end else begin
        if (r_stall) begin
          chk("r_hold_valid", rvalid[g], 1);
          chk("r_hold_payload", {rlast[g], rresp[g], rdata[g]}, r_hold);
        end
        if (rvalid[g]) begin
          if (r_first) begin
            chk_rng("r_latency", cyc - ar_cyc - 1, 1, HI);
            r_first = 0;
          end
          if (rready[g]) begin
            chk("r_expected", rq.size() != 0, 1);
            if (rq.size() != 0) begin
              e = rq.pop_front();
              chk("rdata", rdata[g], e.data);
              chk("rresp", rresp[g], e.resp);
              chk("rlast", rlast[g], e.last);
              if (e.last) r_done++;
            end
            r_stall = 0;
          end else begin
            r_stall = 1;
            r_hold  = {rlast[g], rresp[g], rdata[g]};
          end
        end
        if (b_stall) begin
          chk("b_hold_valid", bvalid[g], 1);
          chk("b_hold_resp", bresp[g], b_hold);
        end
        if (bvalid[g]) begin
          if (b_first) begin
            chk_rng("b_latency", cyc - w_cyc - 1, 1, HI);
            b_first = 0;
          end
          if (bready[g]) begin
            chk("b_expected", bq.size() != 0, 1);
            if (bq.size() != 0) begin
              chk("bresp", bresp[g], bq.pop_front());
              b_done++;
            end
            b_stall = 0;
          end else begin
            b_stall = 1;
            b_hold  = bresp[g];
          end
        end
      end
    end
  end

  task automatic do_write(input int g, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int lead);
    logic [31:0] off;
    logic        oor;
    int n, t, start;
    bit ad, wd;
    off = a - 32'h8000_0000;
    oor = off >= 32'h4000;
    n = 0; t = 0; ad = 0; wd = 0; start = b_done;
    bq.push_back(oor ? 2'b11 : 2'b00);
    if (!oor) for (int i = 0; i < 4; i++) if (s[i]) model[g][off[13:2]][8*i +: 8] = d[8*i +: 8];
    awaddr[g] = a; awlen[g] = 8'd0; awsize[g] = 3'b010;
    wdata[g] = d; wstrb[g] = s; wlast[g] = 1'b1;
    while (!(ad && wd) && n < 60) begin
      awvalid[g] = !ad && (n >= lead);
      wvalid[g]  = !wd && (n >= -lead);
      @(negedge clk);
      if (lead > 0 && wd && !ad) chk("wready_low_after_w", wready[g], 0);
      if (awvalid[g] && awready[g]) begin ad = 1; t = cyc; end
      if (wvalid[g] && wready[g]) begin wd = 1; t = cyc; end
      @(posedge clk);
      #1;
      n++;
    end
    awvalid[g] = 1'b0;
    wvalid[g]  = 1'b0;
    chk("aw_w_handshake", ad && wd, 1);
    w_cyc = t;
    b_first = 1;
    n = 0;
    while (b_done == start && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b_complete", b_done - start, 1);
  endtask

  task automatic do_read(input int g, input logic [31:0] a, input logic [7:0] len, input bit wait_done);
    logic [31:0] off;
    logic        oor;
    logic [11:0] idx;
    rbeat_t      e;
    int n, t, start;
    bit hs;
    off = a - 32'h8000_0000;
    oor = off >= 32'h4000;
    idx = off[13:2];
    n = 0; t = 0; hs = 0; start = r_done;
    for (int i = 0; i <= int'(len); i++) begin
      e.data = oor ? 32'h0 : model[g][idx];
      e.resp = oor ? 2'b11 : 2'b00;
      e.last = (i == int'(len));
      rq.push_back(e);
      idx++;
    end
    araddr[g] = a; arlen[g] = len; arsize[g] = 3'b010; arvalid[g] = 1'b1;
    while (!hs && n < 60) begin
      @(negedge clk);
      hs = arready[g];
      t = cyc;
      @(posedge clk);
      #1;
      n++;
    end
    arvalid[g] = 1'b0;
    chk("ar_handshake", hs, 1);
    ar_cyc = t;
    r_first = 1;
    if (wait_done) begin
      n = 0;
      while (r_done == start && n < 400) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("r_complete", r_done - start, 1);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    for (int g = 0; g < 2; g++) begin
      arvalid[g] = 0; awvalid[g] = 0; wvalid[g] = 0; rready[g] = 1; bready[g] = 1;
      araddr[g] = 0; arlen[g] = 0; arsize[g] = 3'b010; awaddr[g] = 0; awlen[g] = 0;
      awsize[g] = 3'b010; wdata[g] = 0; wstrb[g] = 0; wlast[g] = 1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("reset_arready", arready[g], 0);
      chk("reset_awready", awready[g], 0);
      chk("reset_wready", wready[g], 0);
      chk("reset_rvalid", rvalid[g], 0);
      chk("reset_bvalid", bvalid[g], 0);
    end
    @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("post_reset_arready", arready[g], 1);
      chk("post_reset_awready", awready[g], 1);
      chk("post_reset_wready", wready[g], 1);
      chk("post_reset_rvalid", rvalid[g], 0);
    end
    @(posedge clk);
    #1;

    // Fixed latency: full-word write then read back.
    do_write(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0);
    do_read(0, 32'h8000_0010, 8'd0, 1);

    // Byte strobe: 1122_3344 with lane 2 = AA -> 11AA_3344.
    do_write(0, 32'h8000_0020, 32'h1122_3344, 4'hF, 0);
    do_write(0, 32'h8000_0020, 32'h00AA_0000, 4'b0100, 0);
    do_read(0, 32'h8000_0020, 8'd0, 1);

    // Four-beat burst with rready toggling every cycle.
    for (int i = 0; i < 4; i++) do_write(0, 32'h8000_0000 + 32'(i * 4), 32'h1000_0000 + 32'(i), 4'hF, 0);
    rmode = 1;
    do_read(0, 32'h8000_0000, 8'd3, 1);
    rmode = 0;

    // W ahead of AW by three cycles, then AW ahead of W.
    do_write(0, 32'h8000_0040, 32'hCAFE_F00D, 4'hF, 3);
    do_write(0, 32'h8000_0044, 32'h0BAD_C0DE, 4'hF, -2);
    do_read(0, 32'h8000_0040, 8'd1, 1);

    // Out of range on both sides and at the top edge; word 0 must be untouched.
    do_read(0, 32'h7000_0000, 8'd1, 1);
    do_write(0, 32'h9000_0000, 32'h1234_5678, 4'hF, 0);
    do_write(0, 32'h8000_4000, 32'h8765_4321, 4'hF, 0);
    do_read(0, 32'h8000_0000, 8'd0, 1);

    // Burst wrapping from the last word to word 0.
    do_write(0, 32'h8000_3FFC, 32'hA5A5_0001, 4'hF, 0);
    do_read(0, 32'h8000_3FFC, 8'd1, 1);

    // Random latency instance: initialise a window, then mixed traffic with back-pressure.
    for (int i = 0; i < 40; i++) do_write(1, 32'h8000_0000 + 32'(i * 4), $urandom, 4'hF, 0);
    rmode = 2;
    for (int k = 0; k < 1000; k++) begin
      logic [31:0] a;
      a = (($urandom_range(0, 15) == 0) ? 32'h9000_0000 : 32'h8000_0000) + 32'($urandom_range(0, 31) * 4);
      if ($urandom_range(0, 1) == 1) do_read(1, a, 8'($urandom_range(0, 3)), 1);
      else do_write(1, a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 4)) - 2);
    end

    // Reset in the middle of a burst.
    rmode = 1;
    do_read(1, 32'h8000_0000, 8'd7, 0);
    n = 0;
    while (!rvalid[1] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("burst_started", rvalid[1], 1);
    @(posedge clk);
    #1;
    reset = 1;
    r_first = 0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_reset_rvalid", rvalid[1], 0);
    chk("mid_reset_bvalid", bvalid[1], 0);
    chk("mid_reset_arready", arready[1], 0);
    @(posedge clk);
    #1;
    reset = 0;
    rq.delete();
    bq.delete();
    rmode = 0;
    @(negedge clk);
    chk("after_reset_arready", arready[1], 1);
    chk("after_reset_rvalid", rvalid[1], 0);
    @(posedge clk);
    #1;
    do_read(1, 32'h8000_0004, 8'd0, 1);

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
